// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload.
// Optional period counter output enabled by defining CLK_DIV_PERIOD_CNT_EN.
module clk_div_prog #(
  parameter int unsigned W       = 8,
  parameter int unsigned RST_DIV = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_val,
  input  logic         div_load,
  output logic         load_ack,
  output logic         tick,
  output logic         clk_out,
  output logic [W-1:0] cur_div
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]  period_cnt
`endif
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_n_q, cur_n_d;
  logic [W-1:0] pend_n_q, pend_n_d;
  logic         pend_v_q, pend_v_d;
  logic         tick_q, tick_d;
  logic         clk_out_q, clk_out_d;
  logic         load_ack_q, load_ack_d;

  logic         at_wrap;
  logic         apply;

  // cur_n-1 is only meaningful for cur_n>=2; the guard keeps N=0 from wrapping to all-ones.
  assign at_wrap = (cur_n_q >= W'(2)) && (cnt_q == cur_n_q - W'(1));
  assign apply   = pend_v_q && (!en || (cur_n_q <= W'(1)) || at_wrap);

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d      = cnt_q;
    cur_n_d    = cur_n_q;
    pend_n_d   = pend_n_q;
    pend_v_d   = pend_v_q;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
    load_ack_d = 1'b0;

    if (cur_n_q == '0) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (cur_n_q == W'(1)) begin
      cnt_d  = '0;
      tick_d = en;
      if (en) clk_out_d = 1'b1;
    end else if (en) begin
      tick_d    = (cnt_q == '0);
      clk_out_d = (cnt_q < (cur_n_q >> 1));
      cnt_d     = at_wrap ? '0 : cnt_q + W'(1);
    end

    // A load arriving on the apply cycle supersedes the pending value.
    if (apply) begin
      cur_n_d    = div_load ? div_val : pend_n_q;
      cnt_d      = '0;
      pend_v_d   = 1'b0;
      load_ack_d = 1'b1;
    end else if (div_load) begin
      pend_n_d = div_val;
      pend_v_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_n_q    <= W'(RST_DIV);
      pend_n_q   <= '0;
      pend_v_q   <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_n_q    <= cur_n_d;
      pend_n_q   <= pend_n_d;
      pend_v_q   <= pend_v_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      load_ack_q <= load_ack_d;
    end
  end

  assign load_ack = load_ack_q;
  assign tick     = tick_q;
  assign clk_out  = clk_out_q;
  assign cur_div  = cur_n_q;

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] period_cnt_q, period_cnt_d;

  // Clearing on the apply edge makes period_cnt read 0 in the same cycle load_ack is high.
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (load_ack_d)  period_cnt_d = '0;
    else if (tick_d) period_cnt_d = period_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) period_cnt_q <= '0;
    else     period_cnt_q <= period_cnt_d;
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural period model.
module tb_clk_div_prog;

  localparam int W       = 8;
  localparam int RST_DIV = 3;

  logic         clk = 1'b0;
  logic         rst, en, div_load;
  logic [W-1:0] div_val;
  logic         load_ack, tick, clk_out;
  logic [W-1:0] cur_div;
`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0]  period_cnt;
`endif

  clk_div_prog #(.W(W), .RST_DIV(RST_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .load_ack (load_ack),
    .tick     (tick),
    .clk_out  (clk_out),
    .cur_div  (cur_div)
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: position within the current output period and the divisor in force.
  int m_pos, m_n, m_pend_n, m_pc;
  bit m_pend_v, m_tick, m_clk, m_ack;

  task automatic model_step(input bit r, input bit e, input bit l, input int v);
    bit wrap, app;
    if (r) begin
      m_pos = 0; m_n = RST_DIV; m_pend_v = 0; m_pend_n = 0;
      m_tick = 0; m_clk = 0; m_ack = 0; m_pc = 0;
      return;
    end
    wrap = e && (m_n >= 2) && (m_pos == m_n - 1);
    app  = m_pend_v && (!e || m_n <= 1 || wrap);
    if (m_n == 0) begin
      m_tick = 0; m_clk = 0; m_pos = 0;
    end else if (m_n == 1) begin
      m_tick = e; if (e) m_clk = 1; m_pos = 0;
    end else if (e) begin
      m_tick = (m_pos == 0);
      m_clk  = (m_pos < m_n / 2);
      m_pos  = (m_pos + 1) % m_n;
    end else begin
      m_tick = 0;
    end
    m_ack = app;
    if (app) begin
      m_n = l ? v : m_pend_n;
      m_pos = 0; m_pend_v = 0;
    end else if (l) begin
      m_pend_n = v; m_pend_v = 1;
    end
    if (app)         m_pc = 0;
    else if (m_tick) m_pc = (m_pc + 1) % 65536;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit l, input int v, input string tag);
    rst = r; en = e; div_load = l; div_val = W'(v);
    @(posedge clk);
    model_step(r, e, l, v);
    #1;
    check({tag, ".tick"},     32'(tick),     32'(m_tick));
    check({tag, ".clk_out"},  32'(clk_out),  32'(m_clk));
    check({tag, ".load_ack"}, 32'(load_ack), 32'(m_ack));
    check({tag, ".cur_div"},  32'(cur_div),  32'(m_n));
`ifdef CLK_DIV_PERIOD_CNT_EN
    check({tag, ".period_cnt"}, 32'(period_cnt), 32'(m_pc));
`endif
  endtask

  int ack_seen;

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
    m_pos = 0; m_n = RST_DIV; m_pend_v = 0; m_pend_n = 0;
    m_tick = 0; m_clk = 0; m_ack = 0; m_pc = 0;

    // Reset state
    cyc(1, 0, 0, 0, "reset");
    cyc(1, 0, 0, 0, "reset");
    check("reset_cur_div", 32'(cur_div), 32'(RST_DIV));
    check("reset_clk_out", 32'(clk_out), 32'd0);

    // Divide by 3: tick and clk_out both 1,0,0 repeating
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, "div3");
    check("div3_cur_div", 32'(cur_div), 32'd3);

    // Load 4 at cnt=1; applies at the wrap
    cyc(0, 1, 0, 0, "pre_load4");
    cyc(0, 1, 1, 4, "load4_req");
    cyc(0, 1, 0, 0, "load4_apply");
    check("load4_ack", 32'(load_ack), 32'd1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, "div4");

    // Two loads in one period: only the last is applied, with one ack
    ack_seen = 0;
    cyc(0, 1, 1, 5, "dbl_load5"); ack_seen += int'(load_ack);
    cyc(0, 1, 1, 6, "dbl_load6"); ack_seen += int'(load_ack);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0, "dbl_wait");
      ack_seen += int'(load_ack);
    end
    check("dbl_ack_count", 32'(ack_seen), 32'd1);
    check("dbl_cur_div", 32'(cur_div), 32'd6);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, "div6");

    // Freeze mid-period for 3 cycles
    cyc(0, 1, 0, 0, "pre_freeze");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, "freeze");
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, "resume");

    // Halt with N=0, then N=1
    cyc(0, 1, 1, 0, "load0_req");
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, "halt");
    check("halt_tick", 32'(tick), 32'd0);
    check("halt_clk_out", 32'(clk_out), 32'd0);
    check("halt_cur_div", 32'(cur_div), 32'd0);
    cyc(0, 1, 1, 1, "load1_req");
    cyc(0, 1, 0, 0, "load1_apply");
    check("load1_ack", 32'(load_ack), 32'd1);
    cyc(0, 1, 0, 0, "div1");
    check("div1_tick", 32'(tick), 32'd1);
    check("div1_clk_out", 32'(clk_out), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, "div1");

    // Reset with a load pending: discarded, no ack
    cyc(0, 1, 1, 5, "pend_before_rst");
    cyc(1, 1, 0, 0, "rst_pending");
    check("rst_pend_ack", 32'(load_ack), 32'd0);
    check("rst_pend_cur_div", 32'(cur_div), 32'(RST_DIV));
    check("rst_pend_tick", 32'(tick), 32'd0);
`ifdef CLK_DIV_PERIOD_CNT_EN
    check("rst_pend_period_cnt", 32'(period_cnt), 32'd0);
`endif
    cyc(0, 1, 0, 0, "after_rst");
    check("after_rst_ack", 32'(load_ack), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, e, l;
      int v;
      r = ($urandom_range(0, 149) == 0);
      e = ($urandom_range(0, 4) != 0);
      l = ($urandom_range(0, 11) == 0);
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) % 24
                                      : int'($urandom_range(0, 9));
      cyc(r, e, l, v, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
